// File: rtl/execute_md.sv
// execute_md: execute stage with a registered output slot and an iterative
// RV32M/RV64M multiply/divide unit.
//
// Parameters
//   XLEN            datapath width (32 or 64)
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         kills in-flight M work and the output slot
//   valid_i/ready_o upstream handshake
//   pc_i            instruction PC
//   ex_func_i       ALU operation (encodings listed below)
//   md_en_i         instruction is an M-extension op
//   md_op_i         M funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   rs1_sel_i       1: rs1_data_i, 0: pc_i as ALU operand A
//   rs2_sel_i       1: rs2_data_i, 0: immediate_i as ALU operand B
//   *_en_i, wb_*_i  control sideband, registered alongside the result
//   valid_o/ready_i downstream handshake
//   alu_result_o    result, alu_zero_o = (result == 0)
//   pc_o, pc_4_o, pc_imm_o  PC, PC+4, PC+imm captured at accept
//   busy_o          M operation in flight
//
// ex_func_i encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL,
// 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B; others return 0.
module execute_md #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [3:0]      ex_func_i,
    input  logic            md_en_i,
    input  logic [2:0]      md_op_i,
    input  logic            rs1_sel_i,
    input  logic            rs2_sel_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] immediate_i,
    input  logic            memwrite_en_i,
    input  logic            memread_en_i,
    input  logic            wb_en_i,
    input  logic            wb_src_i,
    input  logic            wb_pc_src_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            alu_zero_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_4_o,
    output logic [XLEN-1:0] pc_imm_o,
    output logic            memwrite_en_o,
    output logic            memread_en_o,
    output logic            wb_en_o,
    output logic            wb_src_o,
    output logic            wb_pc_src_o,
    output logic            busy_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN + 1);

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_SLL  = 4'd5;
    localparam logic [3:0] FN_SRL  = 4'd6;
    localparam logic [3:0] FN_SRA  = 4'd7;
    localparam logic [3:0] FN_SLT  = 4'd8;
    localparam logic [3:0] FN_SLTU = 4'd9;
    localparam logic [3:0] FN_PASS = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    // Iteration registers: {md_hi, md_lo} is the product for MUL*, and
    // md_hi = partial remainder / md_lo = shifting dividend+quotient for DIV*.
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;
    logic [XLEN-1:0] md_b;
    logic [2:0]      h_op;
    logic            h_neg;
    logic            h_rneg;
    logic [XLEN-1:0] h_pc;
    logic [XLEN-1:0] h_pc4;
    logic [XLEN-1:0] h_pcimm;
    logic            h_mw;
    logic            h_mr;
    logic            h_wb;
    logic            h_wbs;
    logic            h_wbpc;

    logic            accept;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] in_pc4;
    logic [XLEN-1:0] in_pcimm;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   md_res;
    logic [XLEN-1:0]   load_res;

    assign ready_o = (state == IDLE) && (!valid_o || ready_i) && !flush_i;
    assign accept  = valid_i && ready_o;
    assign busy_o  = (state != IDLE);

    // ALU with its operand selection
    always_comb begin
        op_a     = rs1_sel_i ? rs1_data_i : pc_i;
        op_b     = rs2_sel_i ? rs2_data_i : immediate_i;
        in_pc4   = pc_i + XLEN'(4);
        in_pcimm = pc_i + immediate_i;
        alu_res  = '0;
        case (ex_func_i)
            FN_ADD:  alu_res = op_a + op_b;
            FN_SUB:  alu_res = op_a - op_b;
            FN_AND:  alu_res = op_a & op_b;
            FN_OR:   alu_res = op_a | op_b;
            FN_XOR:  alu_res = op_a ^ op_b;
            FN_SLL:  alu_res = op_a << op_b[SHW-1:0];
            FN_SRL:  alu_res = op_a >> op_b[SHW-1:0];
            FN_SRA:  alu_res = $signed(op_a) >>> op_b[SHW-1:0];
            FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            FN_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes, signs and the single-cycle division special cases
    always_comb begin
        if (md_op_i[2]) begin
            // DIV/REM signed (funct3 bit0 = 0), DIVU/REMU unsigned
            a_neg = !md_op_i[0] && rs1_data_i[XLEN-1];
            b_neg = !md_op_i[0] && rs2_data_i[XLEN-1];
        end else begin
            a_neg = (md_op_i == 3'd1 || md_op_i == 3'd2) && rs1_data_i[XLEN-1];
            b_neg = (md_op_i == 3'd1) && rs2_data_i[XLEN-1];
        end
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
        div_zero = md_op_i[2] && (rs2_data_i == '0);
        div_ovf  = md_op_i[2] && !md_op_i[0]
                   && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_data_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = md_op_i[1] ? rs1_data_i : '1;
        else
            special_res = md_op_i[1] ? '0 : rs1_data_i;
    end

    // One radix-2 iteration of either shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
        div_shift = {md_hi, md_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, md_b};
        if (!h_op[2]) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], md_lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {md_lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {md_lo[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
        prod_s = h_neg ? -{md_hi, md_lo} : {md_hi, md_lo};
        quo_s  = h_neg ? -md_lo : md_lo;
        rem_s  = h_rneg ? -md_hi : md_hi;
        if (h_op[2])
            md_res = h_op[1] ? rem_s : quo_s;
        else if (h_op[1:0] == 2'd0)
            md_res = prod_s[XLEN-1:0];
        else
            md_res = prod_s[2*XLEN-1:XLEN];
        if (state == DONE)
            load_res = md_res;
        else
            load_res = md_en_i ? special_res : alu_res;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            md_hi         <= '0;
            md_lo         <= '0;
            md_b          <= '0;
            h_op          <= '0;
            h_neg         <= 1'b0;
            h_rneg        <= 1'b0;
            h_pc          <= '0;
            h_pc4         <= '0;
            h_pcimm       <= '0;
            h_mw          <= 1'b0;
            h_mr          <= 1'b0;
            h_wb          <= 1'b0;
            h_wbs         <= 1'b0;
            h_wbpc        <= 1'b0;
            valid_o       <= 1'b0;
            alu_result_o  <= '0;
            alu_zero_o    <= 1'b0;
            pc_o          <= '0;
            pc_4_o        <= '0;
            pc_imm_o      <= '0;
            memwrite_en_o <= 1'b0;
            memread_en_o  <= 1'b0;
            wb_en_o       <= 1'b0;
            wb_src_o      <= 1'b0;
            wb_pc_src_o   <= 1'b0;
        end else begin
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            if (flush_i) begin
                valid_o <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (md_en_i && !special) begin
                                md_hi   <= '0;
                                md_lo   <= a_mag;
                                md_b    <= b_mag;
                                h_op    <= md_op_i;
                                h_neg   <= a_neg ^ b_neg;
                                h_rneg  <= a_neg;
                                h_pc    <= pc_i;
                                h_pc4   <= in_pc4;
                                h_pcimm <= in_pcimm;
                                h_mw    <= memwrite_en_i;
                                h_mr    <= memread_en_i;
                                h_wb    <= wb_en_i;
                                h_wbs   <= wb_src_i;
                                h_wbpc  <= wb_pc_src_i;
                                count   <= CW'(XLEN);
                                state   <= RUN;
                            end else begin
                                valid_o       <= 1'b1;
                                alu_result_o  <= load_res;
                                alu_zero_o    <= (load_res == '0);
                                pc_o          <= pc_i;
                                pc_4_o        <= in_pc4;
                                pc_imm_o      <= in_pcimm;
                                memwrite_en_o <= memwrite_en_i;
                                memread_en_o  <= memread_en_i;
                                wb_en_o       <= wb_en_i;
                                wb_src_o      <= wb_src_i;
                                wb_pc_src_o   <= wb_pc_src_i;
                            end
                        end
                    end
                    RUN: begin
                        md_hi <= step_hi;
                        md_lo <= step_lo;
                        count <= count - CW'(1);
                        if (count == CW'(1))
                            state <= DONE;
                    end
                    DONE: begin
                        if (!valid_o || ready_i) begin
                            valid_o       <= 1'b1;
                            alu_result_o  <= load_res;
                            alu_zero_o    <= (load_res == '0);
                            pc_o          <= h_pc;
                            pc_4_o        <= h_pc4;
                            pc_imm_o      <= h_pcimm;
                            memwrite_en_o <= h_mw;
                            memread_en_o  <= h_mr;
                            wb_en_o       <= h_wb;
                            wb_src_o      <= h_wbs;
                            wb_pc_src_o   <= h_wbpc;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md (XLEN = 32) with hand-computed expectations.
module tb_execute_md;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_SRA = 4'd7;
    localparam logic [3:0] FN_SLT = 4'd8;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            valid_in = 1'b0;
    logic            ready_out;
    logic [XLEN-1:0] pc = '0;
    logic [3:0]      ex_func = '0;
    logic            md_en = 1'b0;
    logic [2:0]      md_op = '0;
    logic            rs1_sel = 1'b0;
    logic            rs2_sel = 1'b0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [XLEN-1:0] imm = '0;
    logic            mw = 1'b0;
    logic            mr = 1'b0;
    logic            wb = 1'b0;
    logic            wbs = 1'b0;
    logic            wbpc = 1'b0;
    logic            valid_out;
    logic            ready_in = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc4_out;
    logic [XLEN-1:0] pcimm_out;
    logic            mw_out;
    logic            mr_out;
    logic            wb_out;
    logic            wbs_out;
    logic            wbpc_out;
    logic            busy;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    execute_md #(.XLEN(XLEN)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .valid_i       (valid_in),
        .ready_o       (ready_out),
        .pc_i          (pc),
        .ex_func_i     (ex_func),
        .md_en_i       (md_en),
        .md_op_i       (md_op),
        .rs1_sel_i     (rs1_sel),
        .rs2_sel_i     (rs2_sel),
        .rs1_data_i    (rs1),
        .rs2_data_i    (rs2),
        .immediate_i   (imm),
        .memwrite_en_i (mw),
        .memread_en_i  (mr),
        .wb_en_i       (wb),
        .wb_src_i      (wbs),
        .wb_pc_src_i   (wbpc),
        .valid_o       (valid_out),
        .ready_i       (ready_in),
        .alu_result_o  (result),
        .alu_zero_o    (zero),
        .pc_o          (pc_out),
        .pc_4_o        (pc4_out),
        .pc_imm_o      (pcimm_out),
        .memwrite_en_o (mw_out),
        .memread_en_o  (mr_out),
        .wb_en_o       (wb_out),
        .wb_src_o      (wbs_out),
        .wb_pc_src_o   (wbpc_out),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [3:0] fn, input logic s1, input logic s2,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] p, input logic [XLEN-1:0] i);
        valid_in = 1'b1;
        md_en    = 1'b0;
        ex_func  = fn;
        rs1_sel  = s1;
        rs2_sel  = s2;
        rs1      = a;
        rs2      = b;
        pc       = p;
        imm      = i;
    endtask

    // Presents one M op for a single cycle (operand selects deliberately 0)
    // and returns the number of edges after the accept edge until valid_o.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output int lat);
        valid_in = 1'b1;
        md_en    = 1'b1;
        md_op    = op;
        rs1_sel  = 1'b0;
        rs2_sel  = 1'b0;
        rs1      = a;
        rs2      = b;
        chk({tag, " ready before accept"}, ready_out, 1'b1);
        step();
        valid_in = 1'b0;
        md_en    = 1'b0;
        lat = 0;
        while (!valid_out && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        // Reset
        step();
        step();
        chk("reset valid", valid_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset result", result, 32'h0);
        chk("reset pc4", pc4_out, 32'h0);
        rst = 1'b0;
        #1;
        chk("ready after reset", ready_out, 1'b1);

        // ALU back-to-back: ADD 5+7, then SUB 7-7
        ready_in = 1'b1;
        wb = 1'b1;
        set_alu(FN_ADD, 1'b1, 1'b1, 32'd5, 32'd7, 32'h1000, 32'h10);
        step();
        chk("add result", result, 32'd12);
        chk("add zero", zero, 1'b0);
        chk("add valid", valid_out, 1'b1);
        chk("add pc", pc_out, 32'h1000);
        chk("add pc4", pc4_out, 32'h1004);
        chk("add pcimm", pcimm_out, 32'h1010);
        chk("add wb_en", wb_out, 1'b1);
        chk("ready during b2b", ready_out, 1'b1);
        set_alu(FN_SUB, 1'b1, 1'b1, 32'd7, 32'd7, 32'h1004, 32'h0);
        step();
        chk("sub result", result, 32'd0);
        chk("sub zero", zero, 1'b1);
        chk("sub valid", valid_out, 1'b1);
        chk("ready after b2b", ready_out, 1'b1);

        // PC/imm operands and wrap of pc+4 / pc+imm
        wb = 1'b0;
        set_alu(FN_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8);
        step();
        chk("pc+imm result", result, 32'd4);
        chk("pc4 wrap", pc4_out, 32'd0);
        chk("pcimm wrap", pcimm_out, 32'd4);
        set_alu(FN_SRA, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        step();
        chk("sra result", result, 32'hF800_0000);
        set_alu(FN_SLT, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("slt result", result, 32'd1);
        valid_in = 1'b0;
        step();
        chk("slot drains", valid_out, 1'b0);

        // Multiplies: -1 * 2
        pc = 32'h40;
        valid_in = 1'b1;
        md_en = 1'b1;
        md_op = OP_MULH;
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'd2;
        step();
        valid_in = 1'b0;
        md_en = 1'b0;
        chk("mulh busy after accept", busy, 1'b1);
        chk("mulh stalls upstream", ready_out, 1'b0);
        lat = 0;
        while (!valid_out && lat < 100) begin
            step();
            lat++;
        end
        chk("mulh latency", lat, 33);
        chk("mulh result", result, 32'hFFFF_FFFF);
        chk("mulh busy at result", busy, 1'b0);
        chk("mulh pc", pc_out, 32'h40);
        run_md("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, lat);
        chk("mul latency", lat, 33);
        chk("mul result", result, 32'hFFFF_FFFE);
        run_md("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, lat);
        chk("mulhu result", result, 32'd1);
        run_md("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, lat);
        chk("mulhsu result", result, 32'hFFFF_FFFF);

        // Signed division: -100 / 7 = -14 rem -2
        run_md("div", OP_DIV, 32'hFFFF_FF9C, 32'd7, lat);
        chk("div result", result, 32'hFFFF_FFF2);
        run_md("rem", OP_REM, 32'hFFFF_FF9C, 32'd7, lat);
        chk("rem result", result, 32'hFFFF_FFFE);

        // Division special cases complete right after the accept edge
        run_md("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div ovf latency", lat, 0);
        chk("div ovf result", result, 32'h8000_0000);
        chk("div ovf busy", busy, 1'b0);
        run_md("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("rem ovf latency", lat, 0);
        chk("rem ovf result", result, 32'h0);
        chk("rem ovf zero", zero, 1'b1);
        run_md("divu by 0", OP_DIVU, 32'd100, 32'd0, lat);
        chk("divu by 0 latency", lat, 0);
        chk("divu by 0 result", result, 32'hFFFF_FFFF);
        run_md("remu by 0", OP_REMU, 32'd100, 32'd0, lat);
        chk("remu by 0 latency", lat, 0);
        chk("remu by 0 result", result, 32'd100);
        step();

        // Backpressure: result held with ready_i low, drained with a new accept
        ready_in = 1'b0;
        run_md("divu bp", OP_DIVU, 32'd100, 32'd7, lat);
        chk("divu bp latency", lat, 33);
        step();
        step();
        chk("bp valid held", valid_out, 1'b1);
        chk("bp result held", result, 32'd14);
        chk("bp ready low", ready_out, 1'b0);
        ready_in = 1'b1;
        set_alu(FN_ADD, 1'b1, 1'b1, 32'd1, 32'd2, 32'h0, 32'h0);
        #1;
        chk("bp ready on drain", ready_out, 1'b1);
        step();
        chk("bp new op result", result, 32'd3);
        chk("bp new op valid", valid_out, 1'b1);
        valid_in = 1'b0;
        step();

        // Flush 10 cycles into a REM
        valid_in = 1'b1;
        md_en = 1'b1;
        md_op = OP_REM;
        rs1 = 32'd100;
        rs2 = 32'd7;
        step();
        valid_in = 1'b0;
        md_en = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
        chk("flush valid", valid_out, 1'b0);
        seen = 0;
        repeat (40) begin
            step();
            if (valid_out) seen++;
        end
        chk("flushed rem never valid", seen, 0);
        set_alu(FN_ADD, 1'b1, 1'b1, 32'd2, 32'd3, 32'h0, 32'h0);
        step();
        valid_in = 1'b0;
        chk("post-flush add", result, 32'd5);
        chk("post-flush valid", valid_out, 1'b1);
        step();

        // Reset while a result is held under backpressure
        ready_in = 1'b0;
        pc = 32'h2000;
        wb = 1'b1;
        run_md("divu rst", OP_DIVU, 32'd100, 32'd7, lat);
        chk("pre-reset result", result, 32'd14);
        chk("pre-reset wb_en", wb_out, 1'b1);
        wb = 1'b0;
        rst = 1'b1;
        step();
        chk("rst valid", valid_out, 1'b0);
        chk("rst result", result, 32'd0);
        chk("rst pc", pc_out, 32'd0);
        chk("rst pc4", pc4_out, 32'd0);
        chk("rst wb_en", wb_out, 1'b0);
        chk("rst busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready after rst", ready_out, 1'b1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
